alu_result_writeback_arbiter: RTL and testbench

- Sits directly downstream of the fcore simple ALU.
- Collects the four ALU result streams (add, fti, itf, mul) and serialises them onto the single register-file write port.
- Each result's user field carries its destination register address.
- The ALU cannot be back-pressured, so each input channel has a small FIFO. A round-robin arbiter drains the FIFOs into one registered output stream.

---
 rtl/alu_result_writeback_arbiter.sv | 147 ++++++++++++++
 tb/tb_alu_result_writeback_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_writeback_arbiter.sv
// Merges the four ALU result streams (add, fti, itf, mul) onto the single register-file write port.
// Each channel has its own FIFO. A round-robin arbiter drains the FIFOs into one registered output.
module alu_result_writeback_arbiter #(
  parameter int DATA_WIDTH          = 32,
  parameter int REGISTER_ADDR_WIDTH = 8,
  parameter int FIFO_DEPTH          = 4
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           add_result_valid,
  input  logic [DATA_WIDTH-1:0]          add_result_data,
  input  logic [REGISTER_ADDR_WIDTH-1:0] add_result_user,
  output logic                           add_result_ready,
  input  logic                           fti_result_valid,
  input  logic [DATA_WIDTH-1:0]          fti_result_data,
  input  logic [REGISTER_ADDR_WIDTH-1:0] fti_result_user,
  output logic                           fti_result_ready,
  input  logic                           itf_result_valid,
  input  logic [DATA_WIDTH-1:0]          itf_result_data,
  input  logic [REGISTER_ADDR_WIDTH-1:0] itf_result_user,
  output logic                           itf_result_ready,
  input  logic                           mul_result_valid,
  input  logic [DATA_WIDTH-1:0]          mul_result_data,
  input  logic [REGISTER_ADDR_WIDTH-1:0] mul_result_user,
  output logic                           mul_result_ready,
  output logic                           writeback_valid,
  output logic [DATA_WIDTH-1:0]          writeback_data,
  output logic [REGISTER_ADDR_WIDTH-1:0] writeback_user,
  input  logic                           writeback_ready,
  input  logic                           clear_overflow,
  output logic [3:0]                     overflow,
  output logic                           busy,
  output logic [1:0]                     dbg_rr_ptr
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = DATA_WIDTH + REGISTER_ADDR_WIDTH;
  localparam logic [AW:0] PTR_ONE = 1;

  // Handshake: a writeback transfer happens on a rising edge where valid and ready are both 1.
  // While valid=1 and ready=0, data, user and valid hold. The ALU inputs cannot stall, so their ready is always 1.
  logic [3:0]            w_in_valid;
  logic [EW-1:0]         w_in_entry [4];
  logic [EW-1:0]         r_mem [4][FIFO_DEPTH];
  logic [AW:0]           r_wr_ptr [4];
  logic [AW:0]           r_rd_ptr [4];
  logic [3:0]            w_empty, w_full, w_push, w_pop, w_drop;
  logic [EW-1:0]         w_head;
  logic [1:0]            r_rr_ptr, w_grant, w_scan;
  logic                  w_grant_valid, w_load;
  logic                  r_wb_valid;
  logic [DATA_WIDTH-1:0] r_wb_data;
  logic [REGISTER_ADDR_WIDTH-1:0] r_wb_user;
  logic [3:0]            r_overflow;

  assign add_result_ready = 1'b1;
  assign fti_result_ready = 1'b1;
  assign itf_result_ready = 1'b1;
  assign mul_result_ready = 1'b1;

  assign w_in_valid    = {mul_result_valid, itf_result_valid, fti_result_valid, add_result_valid};
  assign w_in_entry[0] = {add_result_data, add_result_user};
  assign w_in_entry[1] = {fti_result_data, fti_result_user};
  assign w_in_entry[2] = {itf_result_data, itf_result_user};
  assign w_in_entry[3] = {mul_result_data, mul_result_user};

  assign w_load = !r_wb_valid || writeback_ready;

  always_comb begin
    w_empty = '0;
    w_full  = '0;
    for (int c = 0; c < 4; c++) begin
      w_empty[c] = (r_wr_ptr[c] == r_rd_ptr[c]);
      w_full[c]  = (r_wr_ptr[c][AW] != r_rd_ptr[c][AW]) &&
                   (r_wr_ptr[c][AW-1:0] == r_rd_ptr[c][AW-1:0]);
    end
  end

  // Scan from the furthest candidate back to the pointer, so the nearest non-empty channel wins.
  always_comb begin
    w_grant_valid = 1'b0;
    w_grant       = '0;
    w_scan        = '0;
    for (int k = 3; k >= 0; k--) begin
      w_scan = r_rr_ptr + 2'(k);
      if (!w_empty[w_scan]) begin
        w_grant       = w_scan;
        w_grant_valid = 1'b1;
      end
    end
  end

  always_comb begin
    w_pop  = '0;
    w_push = '0;
    w_drop = '0;
    for (int c = 0; c < 4; c++) begin
      w_pop[c]  = w_load && w_grant_valid && (w_grant == 2'(c));
      w_push[c] = w_in_valid[c] && (!w_full[c] || w_pop[c]);
      w_drop[c] = w_in_valid[c] && w_full[c] && !w_pop[c];
    end
  end

  assign w_head = r_mem[w_grant][r_rd_ptr[w_grant][AW-1:0]];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < 4; c++) begin
        r_wr_ptr[c] <= '0;
        r_rd_ptr[c] <= '0;
      end
      r_rr_ptr   <= '0;
      r_wb_valid <= 1'b0;
      r_wb_data  <= '0;
      r_wb_user  <= '0;
      r_overflow <= '0;
    end else begin
      for (int c = 0; c < 4; c++) begin
        if (w_push[c]) begin
          r_mem[c][r_wr_ptr[c][AW-1:0]] <= w_in_entry[c];
          r_wr_ptr[c] <= r_wr_ptr[c] + PTR_ONE;
        end
        if (w_pop[c]) r_rd_ptr[c] <= r_rd_ptr[c] + PTR_ONE;
      end
      // A drop in the same cycle as a clear leaves the flag set.
      r_overflow <= (clear_overflow ? 4'b0000 : r_overflow) | w_drop;
      if (w_load) begin
        if (w_grant_valid) begin
          r_wb_valid <= 1'b1;
          r_wb_data  <= w_head[EW-1:REGISTER_ADDR_WIDTH];
          r_wb_user  <= w_head[REGISTER_ADDR_WIDTH-1:0];
          r_rr_ptr   <= w_grant + 2'd1;
        end else begin
          r_wb_valid <= 1'b0;
        end
      end
    end
  end

  assign writeback_valid = r_wb_valid;
  assign writeback_data  = r_wb_data;
  assign writeback_user  = r_wb_user;
  assign overflow        = r_overflow;
  assign busy            = (|(~w_empty)) || r_wb_valid;
  assign dbg_rr_ptr      = r_rr_ptr;

endmodule

// File: tb/tb_alu_result_writeback_arbiter.sv
// Bench for alu_result_writeback_arbiter: directed scenarios plus randomized traffic.
// Expected values come from a queue-based reference model.
module tb_alu_result_writeback_arbiter;
  localparam int DW = 32;
  localparam int AW = 8;
  localparam int D  = 4;
  localparam int EW = DW + AW;

  logic          clock = 1'b0;
  logic          reset;
  logic [3:0]    in_valid;
  logic [DW-1:0] in_data [4];
  logic [AW-1:0] in_user [4];
  logic          wb_ready, clear_ov;
  logic [3:0]    in_ready;
  logic          wb_valid, busy;
  logic [DW-1:0] wb_data;
  logic [AW-1:0] wb_user;
  logic [3:0]    overflow;
  logic [1:0]    rr_ptr;

  int checks = 0;
  int failures = 0;

  // Reference model state.
  logic [EW-1:0] exp_q [4][$];
  int            m_ptr;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic [AW-1:0] m_user;
  logic [3:0]    m_ov;

  always #5 clock = ~clock;

  alu_result_writeback_arbiter #(.DATA_WIDTH(DW), .REGISTER_ADDR_WIDTH(AW), .FIFO_DEPTH(D)) dut (
    .clock(clock), .reset(reset),
    .add_result_valid(in_valid[0]), .add_result_data(in_data[0]), .add_result_user(in_user[0]), .add_result_ready(in_ready[0]),
    .fti_result_valid(in_valid[1]), .fti_result_data(in_data[1]), .fti_result_user(in_user[1]), .fti_result_ready(in_ready[1]),
    .itf_result_valid(in_valid[2]), .itf_result_data(in_data[2]), .itf_result_user(in_user[2]), .itf_result_ready(in_ready[2]),
    .mul_result_valid(in_valid[3]), .mul_result_data(in_data[3]), .mul_result_user(in_user[3]), .mul_result_ready(in_ready[3]),
    .writeback_valid(wb_valid), .writeback_data(wb_data), .writeback_user(wb_user), .writeback_ready(wb_ready),
    .clear_overflow(clear_ov), .overflow(overflow), .busy(busy), .dbg_rr_ptr(rr_ptr)
  );

  task automatic model_reset();
    for (int c = 0; c < 4; c++) exp_q[c].delete();
    m_ptr = 0; m_valid = 1'b0; m_data = '0; m_user = '0; m_ov = '0;
  endtask

  // One clock edge of the arbiter rules, evaluated on the current inputs.
  task automatic model_step();
    bit load, gv;
    int g;
    logic [3:0] drop;
    logic [EW-1:0] e;
    load = !m_valid || wb_ready;
    gv = 0; g = 0;
    for (int k = 0; k < 4; k++) begin
      int c;
      c = (m_ptr + k) % 4;
      if (!gv && exp_q[c].size() > 0) begin gv = 1; g = c; end
    end
    if (load && gv) begin
      e = exp_q[g].pop_front();
      m_data = e[EW-1:AW]; m_user = e[AW-1:0]; m_valid = 1'b1;
      m_ptr = (g + 1) % 4;
    end else if (load) begin
      m_valid = 1'b0;
    end
    drop = '0;
    for (int c = 0; c < 4; c++)
      if (in_valid[c]) begin
        if (exp_q[c].size() < D) exp_q[c].push_back({in_data[c], in_user[c]});
        else drop[c] = 1'b1;
      end
    m_ov = (clear_ov ? 4'b0000 : m_ov) | drop;
  endtask

  function automatic bit model_busy();
    bit b;
    b = m_valid;
    for (int c = 0; c < 4; c++) if (exp_q[c].size() > 0) b = 1;
    return b;
  endfunction

  task automatic tick();
    model_step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    in_valid = '0;
    clear_ov = 1'b0;
  endtask

  task automatic push(input int ch, input logic [DW-1:0] d, input logic [AW-1:0] u);
    in_valid[ch] = 1'b1; in_data[ch] = d; in_user[ch] = u;
  endtask

  task automatic do_reset();
    idle_inputs();
    wb_ready = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", wb_valid); end
    checks++; if (wb_data !== '0 || wb_user !== '0) begin failures++; $display("FAIL reset_data got=%h/%h exp=0/0", wb_data, wb_user); end
    checks++; if (overflow !== 4'b0000) begin failures++; $display("FAIL reset_overflow got=%b exp=0000", overflow); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (rr_ptr !== 2'd0) begin failures++; $display("FAIL reset_ptr got=%0d exp=0", rr_ptr); end
  endtask

  task automatic test_single();
    push(0, 32'h3F80_0000, 8'd5);
    tick();
    idle_inputs();
    checks++; if (wb_valid !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL single_stage1 valid=%b busy=%b exp valid=0 busy=1", wb_valid, busy); end
    tick();
    checks++; if (wb_valid !== 1'b1 || wb_data !== 32'h3F80_0000 || wb_user !== 8'd5) begin
      failures++; $display("FAIL single_out valid=%b data=%h user=%0d exp 1/3f800000/5", wb_valid, wb_data, wb_user); end
    tick();
    checks++; if (wb_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL single_done valid=%b busy=%b exp 0/0", wb_valid, busy); end
  endtask

  task automatic test_all_four();
    logic [DW-1:0] exp_d [4];
    exp_d[0] = 32'hA; exp_d[1] = 32'hB; exp_d[2] = 32'hC; exp_d[3] = 32'hD;
    do_reset();
    model_reset();
    for (int c = 0; c < 4; c++) push(c, exp_d[c], 8'(c + 1));
    tick();
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (wb_valid !== 1'b1 || wb_data !== exp_d[i] || wb_user !== 8'(i + 1)) begin
        failures++; $display("FAIL all_four_%0d valid=%b data=%h user=%0d exp 1/%h/%0d", i, wb_valid, wb_data, wb_user, exp_d[i], i + 1); end
    end
    tick();
    checks++; if (wb_valid !== 1'b0 || overflow !== 4'b0000) begin failures++; $display("FAIL all_four_end valid=%b ov=%b exp 0/0000", wb_valid, overflow); end
  endtask

  task automatic test_rr_pointer();
    do_reset();
    model_reset();
    push(1, 32'h30, 8'd7);
    tick();
    idle_inputs();
    tick();
    checks++; if (rr_ptr !== 2'd2) begin failures++; $display("FAIL rr_ptr_setup got=%0d exp=2", rr_ptr); end
    push(0, 32'h31, 8'd8);
    push(3, 32'h33, 8'd9);
    tick();
    idle_inputs();
    tick();
    checks++; if (wb_valid !== 1'b1 || wb_data !== 32'h33) begin failures++; $display("FAIL rr_mul_first valid=%b data=%h exp 1/33", wb_valid, wb_data); end
    tick();
    checks++; if (wb_valid !== 1'b1 || wb_data !== 32'h31) begin failures++; $display("FAIL rr_add_second valid=%b data=%h exp 1/31", wb_valid, wb_data); end
    checks++; if (rr_ptr !== 2'd1) begin failures++; $display("FAIL rr_ptr_end got=%0d exp=1", rr_ptr); end
    tick();
  endtask

  task automatic test_overflow();
    int n;
    do_reset();
    model_reset();
    wb_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      push(3, 32'h100 + DW'(i), 8'(10 + i));
      tick();
      if (i > 0) begin
        checks++; if (wb_valid !== 1'b1 || wb_data !== 32'h100) begin failures++; $display("FAIL ovf_hold_%0d valid=%b data=%h exp 1/100", i, wb_valid, wb_data); end
      end
    end
    idle_inputs();
    checks++; if (overflow !== 4'b1000) begin failures++; $display("FAIL ovf_flag got=%b exp=1000", overflow); end
    wb_ready = 1'b1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (wb_valid) begin
        checks++; if (wb_data !== 32'h100 + DW'(n)) begin failures++; $display("FAIL ovf_drain_%0d got=%h exp=%h", n, wb_data, 32'h100 + n); end
        n++;
      end
      tick();
    end
    checks++; if (n != 5) begin failures++; $display("FAIL ovf_write_count got=%0d exp=5", n); end
    clear_ov = 1'b1;
    tick();
    clear_ov = 1'b0;
    checks++; if (overflow !== 4'b0000) begin failures++; $display("FAIL ovf_clear got=%b exp=0000", overflow); end
  endtask

  task automatic test_full_push_pop();
    int n;
    do_reset();
    model_reset();
    wb_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push(3, 32'h200 + DW'(i), 8'(20 + i));
      tick();
    end
    idle_inputs();
    tick();
    push(3, 32'h205, 8'd25);
    wb_ready = 1'b1;
    tick();
    idle_inputs();
    checks++; if (overflow !== 4'b0000) begin failures++; $display("FAIL fullpp_overflow got=%b exp=0000", overflow); end
    n = 1;
    for (int i = 0; i < 10; i++) begin
      if (wb_valid) begin
        checks++; if (wb_data !== 32'h200 + DW'(n)) begin failures++; $display("FAIL fullpp_drain_%0d got=%h exp=%h", n, wb_data, 32'h200 + n); end
        n++;
      end
      tick();
    end
    checks++; if (n != 6) begin failures++; $display("FAIL fullpp_count got=%0d exp=6", n); end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    model_reset();
    wb_ready = 1'b0;
    push(0, 32'h41, 8'd1); push(1, 32'h42, 8'd2); push(2, 32'h43, 8'd3);
    tick();
    idle_inputs();
    tick();
    checks++; if (wb_valid !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL mid_pre valid=%b busy=%b exp 1/1", wb_valid, busy); end
    #2 reset = 1'b0;
    #1;
    checks++; if (wb_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL mid_async valid=%b busy=%b exp 0/0", wb_valid, busy); end
    model_reset();
    @(negedge clock);
    reset = 1'b1;
    wb_ready = 1'b1;
    @(negedge clock);
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (wb_valid !== 1'b0 || busy !== 1'b0 || rr_ptr !== 2'd0) begin
        failures++; $display("FAIL mid_after_%0d valid=%b busy=%b ptr=%0d exp 0/0/0", i, wb_valid, busy, rr_ptr); end
    end
  endtask

  task automatic test_random();
    do_reset();
    model_reset();
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < 4; c++) begin
        in_valid[c] = ($urandom_range(0, 9) < 3);
        in_data[c]  = $urandom;
        in_user[c]  = 8'($urandom_range(0, 255));
      end
      wb_ready = ($urandom_range(0, 3) != 0) || (i > 380);
      clear_ov = ($urandom_range(0, 15) == 0);
      if (i > 370) in_valid = '0;
      tick();
      checks++; if (wb_valid !== m_valid) begin failures++; $display("FAIL rnd_valid_%0d got=%b exp=%b", i, wb_valid, m_valid); end
      if (m_valid) begin
        checks++; if (wb_data !== m_data || wb_user !== m_user) begin
          failures++; $display("FAIL rnd_data_%0d got=%h/%0d exp=%h/%0d", i, wb_data, wb_user, m_data, m_user); end
      end
      checks++; if (overflow !== m_ov) begin failures++; $display("FAIL rnd_overflow_%0d got=%b exp=%b", i, overflow, m_ov); end
      checks++; if (busy !== model_busy()) begin failures++; $display("FAIL rnd_busy_%0d got=%b exp=%b", i, busy, model_busy()); end
      checks++; if (rr_ptr !== 2'(m_ptr)) begin failures++; $display("FAIL rnd_ptr_%0d got=%0d exp=%0d", i, rr_ptr, m_ptr); end
    end
    idle_inputs();
  endtask

  initial begin
    reset = 1'b1;
    wb_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin in_data[c] = '0; in_user[c] = '0; end
    idle_inputs();
    model_reset();
    test_reset();
    test_single();
    test_all_four();
    test_rr_pointer();
    test_overflow();
    test_full_push_pop();
    test_reset_midstream();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
